// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I core with word-only load/store path and a 32x32 register file
module rv32i_regfile #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] rd_data_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o
);
  logic [31:0] registers [NUM_REGS];
  // clear on reset, otherwise write rd at the clock edge; x0 is never written
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) registers[i] <= '0;
    end else if (we_i && rd_i != 5'd0) begin
      registers[rd_i] <= rd_data_i;
    end
  end
  assign rs1_data_o = (rs1_i == 5'd0) ? 32'd0 : registers[rs1_i];
  assign rs2_data_o = (rs2_i == 5'd0) ? 32'd0 : registers[rs2_i];
endmodule

module rv32i_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_sig,
  output logic [31:0] mem_wr_data,
  output logic [31:0] mem_addr,
  output logic [31:0] rom_addr
);
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  logic [31:0] pc_q, pc_d;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_res, sra_res, wb_data, pc_plus4;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_imm, is_reg;
  logic        taken, wb_en;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign f3     = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'd0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0};

  assign is_lui   = opcode == OP_LUI;
  assign is_auipc = opcode == OP_AUIPC;
  assign is_jal   = opcode == OP_JAL;
  assign is_jalr  = opcode == OP_JALR;
  assign is_br    = opcode == OP_BR;
  assign is_ld    = opcode == OP_LD;
  assign is_st    = opcode == OP_ST;
  assign is_imm   = opcode == OP_IMM;
  assign is_reg   = opcode == OP_REG;

  rv32i_regfile #(.NUM_REGS(NUM_REGS)) reg_file_inst (
    .clk       (clk),
    .reset_n   (reset_n),
    .we_i      (wb_en),
    .rd_i      (rd),
    .rd_data_i (wb_data),
    .rs1_i     (rs1),
    .rs2_i     (rs2),
    .rs1_data_o(rs1_val),
    .rs2_data_o(rs2_val)
  );

  assign alu_b   = is_reg ? rs2_val : imm_i;
  assign sra_res = $signed(rs1_val) >>> alu_b[4:0];

  // ALU: funct3 selects the operation; bit 30 picks SUB (register form only) and SRA/SRAI
  always_comb begin
    alu_res = rs1_val + alu_b;
    case (f3)
      3'b000: alu_res = (is_reg && instruction[30]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001: alu_res = rs1_val << alu_b[4:0];
      3'b010: alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'b011: alu_res = {31'd0, rs1_val < alu_b};
      3'b100: alu_res = rs1_val ^ alu_b;
      3'b101: alu_res = instruction[30] ? sra_res : rs1_val >> alu_b[4:0];
      3'b110: alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  // branch comparator; funct3 010/011 are not valid branches and never take
  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000: taken = rs1_val == rs2_val;
      3'b001: taken = rs1_val != rs2_val;
      3'b100: taken = $signed(rs1_val) < $signed(rs2_val);
      3'b101: taken = $signed(rs1_val) >= $signed(rs2_val);
      3'b110: taken = rs1_val < rs2_val;
      3'b111: taken = rs1_val >= rs2_val;
      default: taken = 1'b0;
    endcase
  end

  assign pc_plus4    = pc_q + 32'd4;
  assign mem_addr    = rs1_val + (is_st ? imm_s : imm_i);
  assign mem_wr_data = rs2_val;
  assign mem_wr_sig  = is_st & reset_n;
  assign rom_addr    = pc_q;

  assign wb_en   = is_lui | is_auipc | is_jal | is_jalr | is_ld | is_imm | is_reg;
  assign wb_data = is_lui ? imm_u :
                   is_auipc ? pc_q + imm_u :
                   (is_jal | is_jalr) ? pc_plus4 :
                   is_ld ? mem_rd_data : alu_res;

  assign pc_d = is_jal ? pc_q + imm_j :
                is_jalr ? {mem_addr[31:1], 1'b0} :
                (is_br && taken) ? pc_q + imm_b : pc_plus4;

  // program counter, one instruction retired per clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  end
endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: directed programs against a behavioural ROM/RAM, checking registers, PC and memory port
module tb_rv32i_core;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BR = 7'b1100011, LD = 7'b0000011, ST = 7'b0100011, OPI = 7'b0010011, OPR = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] instruction, mem_rd_data, mem_wr_data, mem_addr, rom_addr;
  logic        mem_wr_sig;
  logic [31:0] rom [256];
  logic [31:0] ram [256];
  int          asserts = 0;
  int          fails = 0;

  rv32i_core dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instruction(instruction),
    .mem_rd_data(mem_rd_data),
    .mem_wr_sig (mem_wr_sig),
    .mem_wr_data(mem_wr_data),
    .mem_addr   (mem_addr),
    .rom_addr   (rom_addr)
  );

  always #5 clk = ~clk;

  assign instruction = rom[rom_addr[9:2]];
  assign mem_rd_data = ram[mem_addr[9:2]];

  // data RAM: synchronous write, cleared while reset is held across an edge
  always @(posedge clk) begin
    if (!reset_n) for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
    else if (mem_wr_sig) ram[mem_addr[9:2]] <= mem_wr_data;
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], ST};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], BR};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'h0000_006F;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    int nz;
    clear_rom();
    rom[0] = enc_s(12'd64, 5'd0, 5'd0, 3'b010);
    rom[1] = enc_i(12'd1, 5'd0, 3'b000, 5'd1, OPI);
    rom[2] = enc_i(12'd2, 5'd0, 3'b000, 5'd2, OPI);
    do_reset();
    run(3);
    asserts++;
    if (dut.reg_file_inst.registers[2] !== 32'd2) begin fails++; $display("FAIL reset_pre x2 got %h exp %h", dut.reg_file_inst.registers[2], 32'd2); end
    #2 reset_n = 1'b0;
    #1;
    asserts++;
    if (rom_addr !== 32'd0) begin fails++; $display("FAIL reset_async_pc got %h exp %h", rom_addr, 32'd0); end
    asserts++;
    if (mem_wr_sig !== 1'b0) begin fails++; $display("FAIL reset_wr got %b exp 0", mem_wr_sig); end
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.reg_file_inst.registers[i] !== 32'd0) nz++;
    asserts++;
    if (nz != 0) begin fails++; $display("FAIL reset_regs nonzero count got %0d exp 0", nz); end
    @(negedge clk);
    asserts++;
    if (rom_addr !== 32'd0) begin fails++; $display("FAIL reset_hold_pc got %h exp %h", rom_addr, 32'd0); end
    reset_n = 1'b1;
    #1;
    asserts++;
    if (mem_wr_sig !== 1'b1) begin fails++; $display("FAIL reset_release_wr got %b exp 1", mem_wr_sig); end
    @(negedge clk);
    asserts++;
    if (rom_addr !== 32'd4) begin fails++; $display("FAIL reset_pc4 got %h exp %h", rom_addr, 32'd4); end
    run(1);
    asserts++;
    if (rom_addr !== 32'd8) begin fails++; $display("FAIL reset_pc8 got %h exp %h", rom_addr, 32'd8); end
  endtask

  task automatic test_alu();
    logic [31:0] exp [19];
    clear_rom();
    rom[0]  = enc_i(12'hFFB, 5'd0, 3'b000, 5'd1, OPI);
    rom[1]  = enc_i(12'h401, 5'd1, 3'b101, 5'd2, OPI);
    rom[2]  = enc_r(7'h00, 5'd1, 5'd0, 3'b011, 5'd3, OPR);
    rom[3]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4, OPR);
    rom[4]  = enc_i(12'h01C, 5'd1, 3'b101, 5'd5, OPI);
    rom[5]  = enc_r(7'h00, 5'd0, 5'd1, 3'b010, 5'd6, OPR);
    rom[6]  = enc_i(12'hFFF, 5'd1, 3'b100, 5'd7, OPI);
    rom[7]  = enc_r(7'h00, 5'd5, 5'd5, 3'b001, 5'd8, OPR);
    rom[8]  = enc_i(12'h0F0, 5'd1, 3'b111, 5'd9, OPI);
    rom[9]  = enc_i(12'h555, 5'd0, 3'b110, 5'd10, OPI);
    rom[10] = enc_i(12'hFFC, 5'd1, 3'b011, 5'd11, OPI);
    rom[11] = enc_r(7'h20, 5'd5, 5'd1, 3'b101, 5'd12, OPR);
    rom[12] = enc_r(7'h00, 5'd10, 5'd1, 3'b000, 5'd13, OPR);
    rom[13] = enc_i(12'hFFA, 5'd1, 3'b010, 5'd14, OPI);
    rom[14] = enc_r(7'h00, 5'd5, 5'd1, 3'b101, 5'd15, OPR);
    rom[15] = enc_r(7'h00, 5'd7, 5'd6, 3'b110, 5'd16, OPR);
    rom[16] = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd17, OPR);
    rom[17] = enc_r(7'h00, 5'd10, 5'd1, 3'b111, 5'd18, OPR);
    exp[1] = 32'hFFFF_FFFB; exp[2] = 32'hFFFF_FFFD; exp[3] = 32'd1; exp[4] = 32'hFFFF_FFFE;
    exp[5] = 32'h0000_000F; exp[6] = 32'd1; exp[7] = 32'd4; exp[8] = 32'h0007_8000;
    exp[9] = 32'h0000_00F0; exp[10] = 32'h0000_0555; exp[11] = 32'd1; exp[12] = 32'hFFFF_FFFF;
    exp[13] = 32'h0000_0550; exp[14] = 32'd0; exp[15] = 32'h0001_FFFF; exp[16] = 32'd5;
    exp[17] = 32'd6; exp[18] = 32'h0000_0551;
    do_reset();
    run(18);
    for (int k = 1; k < 19; k++) begin
      asserts++;
      if (dut.reg_file_inst.registers[k] !== exp[k]) begin
        fails++;
        $display("FAIL alu x%0d got %h exp %h", k, dut.reg_file_inst.registers[k], exp[k]);
      end
    end
  endtask

  task automatic test_memory();
    clear_rom();
    rom[0] = enc_i(12'd42, 5'd0, 3'b000, 5'd5, OPI);
    rom[1] = enc_s(12'd8, 5'd5, 5'd0, 3'b010);
    rom[2] = enc_i(12'd8, 5'd0, 3'b010, 5'd6, LD);
    rom[3] = enc_i(12'd11, 5'd0, 3'b000, 5'd7, LD);
    rom[4] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd8, OPI);
    rom[5] = enc_s(12'd13, 5'd8, 5'd0, 3'b000);
    rom[6] = enc_i(12'd12, 5'd0, 3'b010, 5'd9, LD);
    do_reset();
    asserts++;
    if (mem_wr_sig !== 1'b0) begin fails++; $display("FAIL mem_wr_addi got %b exp 0", mem_wr_sig); end
    run(1);
    asserts++;
    if (mem_wr_sig !== 1'b1 || mem_addr !== 32'd8 || mem_wr_data !== 32'd42) begin
      fails++; $display("FAIL mem_sw wr/addr/data got %b/%h/%h exp 1/%h/%h", mem_wr_sig, mem_addr, mem_wr_data, 32'd8, 32'd42);
    end
    run(1);
    asserts++;
    if (mem_wr_sig !== 1'b0 || mem_addr !== 32'd8) begin fails++; $display("FAIL mem_lw wr/addr got %b/%h exp 0/%h", mem_wr_sig, mem_addr, 32'd8); end
    run(1);
    asserts++;
    if (dut.reg_file_inst.registers[6] !== 32'd42) begin fails++; $display("FAIL mem_lw_x6 got %h exp %h", dut.reg_file_inst.registers[6], 32'd42); end
    run(2);
    asserts++;
    if (mem_wr_sig !== 1'b1 || mem_addr !== 32'd13) begin fails++; $display("FAIL mem_sb wr/addr got %b/%h exp 1/%h", mem_wr_sig, mem_addr, 32'd13); end
    run(2);
    asserts++;
    if (dut.reg_file_inst.registers[7] !== 32'd42) begin fails++; $display("FAIL mem_lb_x7 got %h exp %h", dut.reg_file_inst.registers[7], 32'd42); end
    asserts++;
    if (dut.reg_file_inst.registers[9] !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mem_lw_x9 got %h exp %h", dut.reg_file_inst.registers[9], 32'hFFFF_FFFF); end
    asserts++;
    if (ram[2] !== 32'd42 || ram[3] !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mem_ram w2/w3 got %h/%h exp %h/%h", ram[2], ram[3], 32'd42, 32'hFFFF_FFFF); end
  endtask

  task automatic test_branch();
    clear_rom();
    rom[0]  = enc_i(12'd3, 5'd0, 3'b000, 5'd1, OPI);
    rom[1]  = enc_i(12'd3, 5'd0, 3'b000, 5'd2, OPI);
    rom[2]  = enc_b(13'd8, 5'd2, 5'd1, 3'b000);
    rom[3]  = enc_i(12'd1, 5'd0, 3'b000, 5'd3, OPI);
    rom[4]  = enc_j(21'd44, 5'd4);
    rom[5]  = enc_i(12'd9, 5'd0, 3'b000, 5'd5, OPI);
    rom[6]  = enc_i(12'hFFF, 5'd0, 3'b000, 5'd6, OPI);
    rom[7]  = enc_b(13'd8, 5'd6, 5'd1, 3'b100);
    rom[8]  = enc_i(12'd1, 5'd0, 3'b000, 5'd7, OPI);
    rom[9]  = enc_b(13'd8, 5'd1, 5'd6, 3'b111);
    rom[10] = enc_i(12'd1, 5'd0, 3'b000, 5'd8, OPI);
    rom[11] = enc_b(13'd8, 5'd2, 5'd1, 3'b001);
    rom[12] = enc_i(12'd1, 5'd0, 3'b000, 5'd9, OPI);
    rom[15] = enc_i(12'd1, 5'd4, 3'b000, 5'd10, JALR);
    do_reset();
    run(3);
    asserts++;
    if (rom_addr !== 32'd16) begin fails++; $display("FAIL br_beq_taken pc got %h exp %h", rom_addr, 32'd16); end
    run(1);
    asserts++;
    if (rom_addr !== 32'd60) begin fails++; $display("FAIL br_jal pc got %h exp %h", rom_addr, 32'd60); end
    asserts++;
    if (dut.reg_file_inst.registers[4] !== 32'd20) begin fails++; $display("FAIL br_jal_link got %h exp %h", dut.reg_file_inst.registers[4], 32'd20); end
    run(1);
    asserts++;
    if (rom_addr !== 32'd20 || dut.reg_file_inst.registers[10] !== 32'd64) begin
      fails++; $display("FAIL br_jalr pc/link got %h/%h exp %h/%h", rom_addr, dut.reg_file_inst.registers[10], 32'd20, 32'd64);
    end
    run(8);
    asserts++;
    if (rom_addr !== 32'd52) begin fails++; $display("FAIL br_end pc got %h exp %h", rom_addr, 32'd52); end
    asserts++;
    if (dut.reg_file_inst.registers[3] !== 32'd0 || dut.reg_file_inst.registers[8] !== 32'd0) begin
      fails++; $display("FAIL br_skipped x3/x8 got %h/%h exp 0/0", dut.reg_file_inst.registers[3], dut.reg_file_inst.registers[8]);
    end
    asserts++;
    if (dut.reg_file_inst.registers[5] !== 32'd9 || dut.reg_file_inst.registers[7] !== 32'd1 || dut.reg_file_inst.registers[9] !== 32'd1) begin
      fails++; $display("FAIL br_fallthrough x5/x7/x9 got %h/%h/%h exp 9/1/1", dut.reg_file_inst.registers[5], dut.reg_file_inst.registers[7], dut.reg_file_inst.registers[9]);
    end
  endtask

  task automatic test_x0_upper();
    clear_rom();
    rom[0] = enc_i(12'd7, 5'd0, 3'b000, 5'd0, OPI);
    rom[1] = enc_u(20'h12345, 5'd7, LUI);
    rom[2] = 32'h0000_0073;
    rom[3] = 32'h0000_000F;
    rom[4] = enc_u(20'h00001, 5'd8, AUIPC);
    rom[5] = enc_i(12'd5, 5'd0, 3'b000, 5'd9, OPI);
    do_reset();
    run(6);
    asserts++;
    if (dut.reg_file_inst.registers[0] !== 32'd0) begin fails++; $display("FAIL x0_write got %h exp 0", dut.reg_file_inst.registers[0]); end
    asserts++;
    if (dut.reg_file_inst.registers[7] !== 32'h1234_5000) begin fails++; $display("FAIL lui got %h exp %h", dut.reg_file_inst.registers[7], 32'h1234_5000); end
    asserts++;
    if (dut.reg_file_inst.registers[8] !== 32'h0000_1010) begin fails++; $display("FAIL auipc got %h exp %h", dut.reg_file_inst.registers[8], 32'h0000_1010); end
    asserts++;
    if (dut.reg_file_inst.registers[9] !== 32'd5 || rom_addr !== 32'd24) begin
      fails++; $display("FAIL x0_read x9/pc got %h/%h exp %h/%h", dut.reg_file_inst.registers[9], rom_addr, 32'd5, 32'd24);
    end
  endtask

  task automatic test_program();
    clear_rom();
    rom[0]  = enc_i(12'd1020, 5'd0, 3'b000, 5'd2, OPI);
    rom[1]  = enc_i(12'd10, 5'd0, 3'b000, 5'd10, OPI);
    rom[2]  = enc_j(21'd12, 5'd1);
    rom[3]  = enc_i(12'd0, 5'd10, 3'b000, 5'd29, OPI);
    rom[5]  = enc_b(13'd8, 5'd0, 5'd10, 3'b001);
    rom[6]  = enc_i(12'd0, 5'd1, 3'b000, 5'd0, JALR);
    rom[7]  = enc_i(12'hFF8, 5'd2, 3'b000, 5'd2, OPI);
    rom[8]  = enc_s(12'd4, 5'd1, 5'd2, 3'b010);
    rom[9]  = enc_s(12'd0, 5'd10, 5'd2, 3'b010);
    rom[10] = enc_i(12'hFFF, 5'd10, 3'b000, 5'd10, OPI);
    rom[11] = enc_j(21'h1F_FFE8, 5'd1);
    rom[12] = enc_i(12'd0, 5'd2, 3'b010, 5'd11, LD);
    rom[13] = enc_i(12'd4, 5'd2, 3'b010, 5'd1, LD);
    rom[14] = enc_r(7'h00, 5'd11, 5'd10, 3'b000, 5'd10, OPR);
    rom[15] = enc_i(12'd8, 5'd2, 3'b000, 5'd2, OPI);
    rom[16] = enc_i(12'd0, 5'd1, 3'b000, 5'd0, JALR);
    do_reset();
    for (int c = 0; c < 500 && dut.reg_file_inst.registers[29] !== 32'd55; c++) @(negedge clk);
    asserts++;
    if (dut.reg_file_inst.registers[29] !== 32'd55) begin fails++; $display("FAIL prog_sum x29 got %0d exp 55 within 500 cycles", dut.reg_file_inst.registers[29]); end
    asserts++;
    if (dut.reg_file_inst.registers[2] !== 32'd1020) begin fails++; $display("FAIL prog_sp got %0d exp 1020", dut.reg_file_inst.registers[2]); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_memory();
    test_branch();
    test_x0_upper();
    test_program();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
